// File: rtl/port_write_scheduler.sv
// Serialises CPU and timer read-modify-write requests onto the output port register,
// keeping a shadow copy of the port so set/clear/toggle can be applied under the ddr mask.
module port_write_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic [1:0]       cpu_op,
  input  logic [WIDTH-1:0] cpu_data,
  output logic             cpu_ack,
  input  logic             tmr_req,
  input  logic [1:0]       tmr_op,
  input  logic [WIDTH-1:0] tmr_data,
  output logic             tmr_ack,
  input  logic [WIDTH-1:0] ddr,
  output logic             port_write_en,
  output logic [WIDTH-1:0] port_data_in,
  output logic [WIDTH-1:0] shadow,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_WRITE,
    S_ACK
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] pdata_q, pdata_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             grant_tmr_q, grant_tmr_d;
  logic             last_tmr_q, last_tmr_d;
  logic             pick_tmr;
  logic [WIDTH-1:0] op_result;

  // Candidate value for the masked bits, derived from the latched op and operand.
  always_comb begin
    op_result = data_q;
    case (op_q)
      OP_WRITE:  op_result = data_q;
      OP_SET:    op_result = shadow_q | data_q;
      OP_CLEAR:  op_result = shadow_q & ~data_q;
      OP_TOGGLE: op_result = shadow_q ^ data_q;
      default:   op_result = data_q;
    endcase
  end

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    pdata_d     = pdata_q;
    op_d        = op_q;
    data_d      = data_q;
    mask_d      = mask_q;
    grant_tmr_d = grant_tmr_q;
    last_tmr_d  = last_tmr_q;
    pick_tmr    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || tmr_req) begin
          // Round-robin: on a tie the requester not served last time wins.
          pick_tmr    = tmr_req && (!cpu_req || !last_tmr_q);
          grant_tmr_d = pick_tmr;
          last_tmr_d  = pick_tmr;
          op_d        = op_t'(pick_tmr ? tmr_op : cpu_op);
          data_d      = pick_tmr ? tmr_data : cpu_data;
          mask_d      = ddr;
          state_d     = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        pdata_d = (shadow_q & ~mask_q) | (op_result & mask_q);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Shadow follows the port register on the very edge the port captures.
        shadow_d = pdata_q;
        state_d  = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      pdata_q     <= '0;
      op_q        <= OP_WRITE;
      data_q      <= '0;
      mask_q      <= '0;
      grant_tmr_q <= 1'b0;
      last_tmr_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      pdata_q     <= pdata_d;
      op_q        <= op_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      grant_tmr_q <= grant_tmr_d;
      last_tmr_q  <= last_tmr_d;
    end
  end

  assign port_write_en = (state_q == S_WRITE);
  assign port_data_in  = pdata_q;
  assign shadow        = shadow_q;
  assign busy          = (state_q != S_IDLE);
  assign cpu_ack       = (state_q == S_ACK) && !grant_tmr_q;
  assign tmr_ack       = (state_q == S_ACK) &&  grant_tmr_q;

endmodule
